// File: rtl/pulse_pattern_receiver.sv
// Receive end of the serial pulse link: captures a WIDTH-bit pattern MSB-first, then
// verifies that the stream keeps repeating it, reporting lock and a saturating error count.
module pulse_pattern_receiver #(
  parameter int WIDTH = 16,
  parameter int ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_BIT  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    VERIFY  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               word_valid_q, word_valid_d;
  logic               mismatch_q, mismatch_d;
  logic               locked_q, locked_d;
  logic               busy_q;

  logic [WIDTH-1:0]   captured_word;
  logic [WIDTH-1:0]   first_sample;
  logic               expected_bit;

  assign captured_word = {shreg_q[WIDTH-2:0], serial_in};
  // A new capture always begins with the current sample as bit 1, so nothing is dropped.
  assign first_sample  = {{(WIDTH-1){1'b0}}, serial_in};
  assign expected_bit  = ref_q[WIDTH-1];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      ref_q        <= '0;
      word_q       <= '0;
      bitcnt_q     <= '0;
      err_q        <= '0;
      word_valid_q <= 1'b0;
      mismatch_q   <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      ref_q        <= ref_d;
      word_q       <= word_d;
      bitcnt_q     <= bitcnt_d;
      err_q        <= err_d;
      word_valid_q <= word_valid_d;
      mismatch_q   <= mismatch_d;
      locked_q     <= locked_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    ref_d        = ref_q;
    word_d       = word_q;
    bitcnt_d     = bitcnt_q;
    err_d        = err_q;
    word_valid_d = 1'b0;
    mismatch_d   = 1'b0;
    locked_d     = locked_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          shreg_d  = first_sample;
          bitcnt_d = ONE_BIT;
        end
      end

      CAPTURE: begin
        if (start) begin
          shreg_d  = first_sample;
          bitcnt_d = ONE_BIT;
          locked_d = 1'b0;
        end else if (bitcnt_q == LAST_BIT) begin
          shreg_d      = captured_word;
          word_d       = captured_word;
          ref_d        = captured_word;
          word_valid_d = 1'b1;
          bitcnt_d     = '0;
          state_d      = VERIFY;
        end else begin
          shreg_d  = captured_word;
          bitcnt_d = bitcnt_q + ONE_BIT;
        end
      end

      VERIFY: begin
        // A restart request takes priority and is not treated as an error.
        if (start) begin
          state_d  = CAPTURE;
          shreg_d  = first_sample;
          bitcnt_d = ONE_BIT;
          locked_d = 1'b0;
        end else if (serial_in == expected_bit) begin
          ref_d = {ref_q[WIDTH-2:0], ref_q[WIDTH-1]};
          if (bitcnt_q == LAST_BIT) begin
            locked_d = 1'b1;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + ONE_BIT;
          end
        end else begin
          mismatch_d = 1'b1;
          locked_d   = 1'b0;
          if (!(&err_q)) begin
            err_d = err_q + ERR_W'(1);
          end
          state_d  = CAPTURE;
          shreg_d  = first_sample;
          bitcnt_d = ONE_BIT;
        end
      end

      default: begin
        state_d  = IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pulse_pattern_receiver.sv
// Directed bench for pulse_pattern_receiver: feeds a circulating 16-bit stream and checks
// capture, lock, mismatch recovery, restart, reset and error-count saturation.
module tb_pulse_pattern_receiver;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        serial_in;
  logic [15:0] word_out;
  logic        word_valid;
  logic        locked;
  logic        mismatch;
  logic [7:0]  err_count;
  logic        busy;

  int          n_cmp;
  int          n_err;
  logic [15:0] pat;
  int          k;

  pulse_pattern_receiver #(.WIDTH(16), .ERR_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .serial_in  (serial_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .locked     (locked),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic tick(input logic s, input logic b);
    start     = s;
    serial_in = b;
    @(posedge clock);
    #1;
    start     = 1'b0;
  endtask

  task automatic feed(input logic s, input int n);
    for (int i = 0; i < n; i++) begin
      tick((i == 0) ? s : 1'b0, pat[15 - (k % 16)]);
      k++;
    end
  endtask

  task automatic rst_tick(input logic s);
    reset_n = 1'b0;
    tick(s, 1'b1);
    reset_n = 1'b1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_word"},  {16'h0, word_out}, 32'h0);
    check_eq({tag, "_valid"}, {31'h0, word_valid}, 32'h0);
    check_eq({tag, "_lock"},  {31'h0, locked}, 32'h0);
    check_eq({tag, "_mism"},  {31'h0, mismatch}, 32'h0);
    check_eq({tag, "_err"},   {24'h0, err_count}, 32'h0);
    check_eq({tag, "_busy"},  {31'h0, busy}, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    start = 1'b0;
    serial_in = 1'b0;
    pat = 16'hA5C3;
    k = 0;

    // Reset, with start held during reset (must be ignored)
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    reset_n = 1'b1;
    check_idle_zero("reset");
    tick(1'b0, 1'b0);
    check_eq("idle_after_reset_busy", {31'h0, busy}, 32'h0);

    // 1: capture A5C3 in phase, lock after 32 cycles
    pat = 16'hA5C3;
    k = 0;
    feed(1'b1, 15);
    check_eq("t1_valid_early", {31'h0, word_valid}, 32'h0);
    check_eq("t1_busy", {31'h0, busy}, 32'h1);
    feed(1'b0, 1);
    check_eq("t1_valid", {31'h0, word_valid}, 32'h1);
    check_eq("t1_word", {16'h0, word_out}, 32'hA5C3);
    feed(1'b0, 1);
    check_eq("t1_valid_pulse", {31'h0, word_valid}, 32'h0);
    feed(1'b0, 14);
    check_eq("t1_lock_early", {31'h0, locked}, 32'h0);
    feed(1'b0, 1);
    check_eq("t1_lock", {31'h0, locked}, 32'h1);
    check_eq("t1_err", {24'h0, err_count}, 32'h0);
    feed(1'b0, 16);
    check_eq("t1_lock_hold", {31'h0, locked}, 32'h1);

    // 2: flip one bit; it becomes bit 1 of a capture holding 25C3, which then mismatches
    tick(1'b0, ~pat[15 - (k % 16)]);
    k++;
    check_eq("t2_mism", {31'h0, mismatch}, 32'h1);
    check_eq("t2_lock", {31'h0, locked}, 32'h0);
    check_eq("t2_err", {24'h0, err_count}, 32'h1);
    check_eq("t2_valid_none", {31'h0, word_valid}, 32'h0);
    feed(1'b0, 14);
    check_eq("t2_valid_early", {31'h0, word_valid}, 32'h0);
    feed(1'b0, 1);
    check_eq("t2_valid", {31'h0, word_valid}, 32'h1);
    check_eq("t2_word_bad", {16'h0, word_out}, 32'h25C3);
    check_eq("t2_mism_gone", {31'h0, mismatch}, 32'h0);
    feed(1'b0, 1);
    check_eq("t2_mism2", {31'h0, mismatch}, 32'h1);
    check_eq("t2_err2", {24'h0, err_count}, 32'h2);
    feed(1'b0, 15);
    check_eq("t2_valid2", {31'h0, word_valid}, 32'h1);
    check_eq("t2_word_good", {16'h0, word_out}, 32'hA5C3);
    feed(1'b0, 15);
    check_eq("t2_relock_early", {31'h0, locked}, 32'h0);
    feed(1'b0, 1);
    check_eq("t2_relock", {31'h0, locked}, 32'h1);
    check_eq("t2_err_hold", {24'h0, err_count}, 32'h2);

    // 5: start during VERIFY at phase 4 restarts without an error
    feed(1'b0, 4);
    check_eq("t5_locked_before", {31'h0, locked}, 32'h1);
    feed(1'b1, 1);
    check_eq("t5_lock", {31'h0, locked}, 32'h0);
    check_eq("t5_mism", {31'h0, mismatch}, 32'h0);
    check_eq("t5_err", {24'h0, err_count}, 32'h2);
    check_eq("t5_word_kept", {16'h0, word_out}, 32'hA5C3);
    feed(1'b0, 14);
    check_eq("t5_valid_early", {31'h0, word_valid}, 32'h0);
    feed(1'b0, 1);
    check_eq("t5_valid", {31'h0, word_valid}, 32'h1);
    check_eq("t5_word", {16'h0, word_out}, 32'h5C3A);
    feed(1'b0, 16);
    check_eq("t5_lock_again", {31'h0, locked}, 32'h1);
    check_eq("t5_err_final", {24'h0, err_count}, 32'h2);

    // 3: start 4 bits late after reset -> rotated word 5C3A
    rst_tick(1'b0);
    check_idle_zero("t3_reset");
    k = 4;
    feed(1'b1, 16);
    check_eq("t3_valid", {31'h0, word_valid}, 32'h1);
    check_eq("t3_word", {16'h0, word_out}, 32'h5C3A);
    feed(1'b0, 16);
    check_eq("t3_lock", {31'h0, locked}, 32'h1);
    check_eq("t3_err", {24'h0, err_count}, 32'h0);

    // 4: reset at cycle 7 of a capture, start held on the reset edge
    k = 0;
    feed(1'b1, 7);
    check_eq("t4_busy", {31'h0, busy}, 32'h1);
    rst_tick(1'b1);
    check_idle_zero("t4_reset");
    tick(1'b0, 1'b1);
    check_eq("t4_idle", {31'h0, busy}, 32'h0);
    k = 0;
    feed(1'b1, 16);
    check_eq("t4_valid", {31'h0, word_valid}, 32'h1);
    check_eq("t4_word", {16'h0, word_out}, 32'hA5C3);
    feed(1'b0, 16);
    check_eq("t4_lock", {31'h0, locked}, 32'h1);

    // 6: alternating 16-bit blocks of ones/zeros give one mismatch per block
    rst_tick(1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0);
    check_eq("t6_valid0", {31'h0, word_valid}, 32'h1);
    check_eq("t6_word0", {16'h0, word_out}, 32'h0000);
    for (int b = 1; b <= 300; b++) begin
      tick(1'b0, b[0]);
      if (b == 1 || b == 2 || b == 254 || b == 255 || b == 256 || b == 300) begin
        check_eq($sformatf("t6_mism_b%0d", b), {31'h0, mismatch}, 32'h1);
        check_eq($sformatf("t6_err_b%0d", b), {24'h0, err_count}, (b > 255) ? 32'd255 : b);
      end
      for (int i = 0; i < 15; i++) tick(1'b0, b[0]);
      if (b == 299) check_eq("t6_word_ones", {16'h0, word_out}, 32'hFFFF);
    end
    check_eq("t6_word_zeros", {16'h0, word_out}, 32'h0000);
    check_eq("t6_err_sat", {24'h0, err_count}, 32'hFF);

    // Constant patterns lock
    rst_tick(1'b0);
    pat = 16'h0000;
    k = 0;
    feed(1'b1, 16);
    check_eq("c0_word", {16'h0, word_out}, 32'h0000);
    check_eq("c0_valid", {31'h0, word_valid}, 32'h1);
    feed(1'b0, 16);
    check_eq("c0_lock", {31'h0, locked}, 32'h1);
    rst_tick(1'b0);
    pat = 16'hFFFF;
    k = 0;
    feed(1'b1, 16);
    check_eq("c1_word", {16'h0, word_out}, 32'hFFFF);
    feed(1'b0, 16);
    check_eq("c1_lock", {31'h0, locked}, 32'h1);
    check_eq("c1_err", {24'h0, err_count}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
